// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_pkg
// Description : Shared types and constants for the seven_segment_n display
//               driver: conversion FSM states, active-high segment patterns
//               and the BCD digit-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_pkg;

    // Conversion FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SHIFT   = 2'd2,
        S_COMMIT  = 2'd3
    } conv_state_e;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Decimal digits needed to hold 2^width-1: ceil(width * log10(2))
    function automatic int bcdDigits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd
// Description : Sequential double-dabble converter. A start pulse captures
//               bin; the conversion then takes exactly VALUE_WIDTH cycles.
//               done is high during the final shift cycle, so bcd holds the
//               finished result from the following cycle on and stays stable
//               until the next start.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd
    import seven_segment_pkg::*;
#(
    parameter  int VALUE_WIDTH = 16,
    localparam int BCD_W       = 4 * bcdDigits(VALUE_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   start,
    input  logic [VALUE_WIDTH-1:0] bin,
    output logic                   done,
    output logic [BCD_W-1:0]       bcd
);

    localparam int c_STEP_W = $clog2(VALUE_WIDTH + 1);

    logic [VALUE_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [c_STEP_W-1:0]    r_steps;
    logic [BCD_W-1:0]       w_adj;
    logic                   w_unusedAdjMsb;

    // Add 3 to every BCD nibble that is 5 or more before the next shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The result always fits, so the top adjusted bit is shifted out as zero
    assign w_unusedAdjMsb = w_adj[BCD_W-1];

    // Load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_bin   <= '0;
            r_bcd   <= '0;
            r_steps <= '0;
        end else if (start) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_steps <= c_STEP_W'(VALUE_WIDTH);
        end else if (r_steps != '0) begin
            r_bcd   <= {w_adj[BCD_W-2:0], r_bin[VALUE_WIDTH-1]};
            r_bin   <= r_bin << 1;
            r_steps <= r_steps - 1'b1;
        end
    end

    assign done = (r_steps == c_STEP_W'(1));
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seven_segment_n.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_n
// Description : Time-multiplexed N-digit seven-segment driver with hex or
//               decimal rendering, leading-zero blanking and overflow dashes.
//               Define SEVEN_SEGMENT_DECIMAL_EN to build the decimal path;
//               without it decimalMode is ignored and values render as hex.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_n
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int VALUE_WIDTH    = 16,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   load,
    input  logic                   decimalMode,
    input  logic                   blankZeros,
    output logic [6:0]             segs,
    output logic [NUM_DIGITS-1:0]  sel,
    output logic                   busy,
    output logic                   overflow
);

    localparam int c_CNT_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough for any zero-extended value or BCD result
    localparam int c_EXT_W = 64;
    localparam logic [6:0]            c_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] c_SEL_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

    conv_state_e            r_state;
    logic [VALUE_WIDTH-1:0] r_capValue;
    logic                   r_pendValid;
    logic [VALUE_WIDTH-1:0] r_pendValue;
    logic [3:0]             r_digits [NUM_DIGITS];
    logic                   r_overflow;
    logic [c_CNT_W-1:0]     r_refreshCnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [6:0]             r_segs;
    logic [NUM_DIGITS-1:0]  r_sel;

    logic [c_EXT_W-1:0]     w_ext;
    logic                   w_newOverflow;
    logic [NUM_DIGITS-1:0]  w_blank;
    logic [6:0]             w_curSeg;
    logic [NUM_DIGITS-1:0]  w_selOneHot;

`ifdef SEVEN_SEGMENT_DECIMAL_EN
    localparam int c_BCD_W = 4 * bcdDigits(VALUE_WIDTH);

    logic               r_capDec;
    logic               r_pendDec;
    logic               w_bcdStart;
    logic               w_bcdDone;
    logic [c_BCD_W-1:0] w_bcd;

    assign w_bcdStart = (r_state == S_CAPTURE) && r_capDec;

    binary_to_bcd #(
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_bcd (
        .clk   (clk),
        .rstN  (rstN),
        .start (w_bcdStart),
        .bin   (r_capValue),
        .done  (w_bcdDone),
        .bcd   (w_bcd)
    );

    // Commit source: finished BCD for decimal, the captured value for hex
    assign w_ext = r_capDec ? c_EXT_W'(w_bcd) : c_EXT_W'(r_capValue);
`else
    logic w_unusedDecimal;

    // Decimal requests render as hex in this build
    assign w_unusedDecimal = decimalMode;
    assign w_ext           = c_EXT_W'(r_capValue);
`endif

    // Any nonzero digit beyond the physical display is an overflow
    assign w_newOverflow = |(w_ext >> (4 * NUM_DIGITS));

    // Conversion FSM with one-entry pending slot; digits change only in COMMIT
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_capValue  <= '0;
            r_pendValid <= 1'b0;
            r_pendValue <= '0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digits[i] <= 4'd0;
            end
`ifdef SEVEN_SEGMENT_DECIMAL_EN
            r_capDec    <= 1'b0;
            r_pendDec   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_capValue <= value;
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                        r_capDec   <= decimalMode;
`endif
                        r_state    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                    r_state <= r_capDec ? S_SHIFT : S_COMMIT;
`else
                    r_state <= S_COMMIT;
`endif
                    if (load) begin
                        r_pendValid <= 1'b1;
                        r_pendValue <= value;
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                        r_pendDec   <= decimalMode;
`endif
                    end
                end
                S_SHIFT: begin
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                    if (w_bcdDone) begin
                        r_state <= S_COMMIT;
                    end
`else
                    r_state <= S_COMMIT;
`endif
                    if (load) begin
                        r_pendValid <= 1'b1;
                        r_pendValue <= value;
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                        r_pendDec   <= decimalMode;
`endif
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        r_digits[i] <= w_ext[4*i +: 4];
                    end
                    r_overflow <= w_newOverflow;
                    // A load arriving in this cycle is newer than the slot
                    if (load) begin
                        r_capValue  <= value;
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                        r_capDec    <= decimalMode;
`endif
                        r_pendValid <= 1'b0;
                        r_state     <= S_CAPTURE;
                    end else if (r_pendValid) begin
                        r_capValue  <= r_pendValue;
`ifdef SEVEN_SEGMENT_DECIMAL_EN
                        r_capDec    <= r_pendDec;
`endif
                        r_pendValid <= 1'b0;
                        r_state     <= S_CAPTURE;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign overflow = r_overflow;

    // Blank digit i>0 when it and every digit above it are zero
    always_comb begin
        logic v_zeroRun;
        v_zeroRun = 1'b1;
        w_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_zeroRun  = v_zeroRun && (r_digits[i] == 4'd0);
            w_blank[i] = blankZeros && v_zeroRun && (i != 0);
        end
    end

    // Active-high pattern for the currently selected digit
    always_comb begin
        if (r_overflow) begin
            w_curSeg = SEG_DASH;
        end else if (w_blank[r_idx]) begin
            w_curSeg = SEG_BLANK;
        end else begin
            w_curSeg = SEG_HEX[r_digits[r_idx]];
        end
    end

    assign w_selOneHot = NUM_DIGITS'(1) << r_idx;

    // Refresh counter and digit index; each digit held REFRESH_DIV cycles
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_refreshCnt <= '0;
            r_idx        <= '0;
        end else if (r_refreshCnt == c_CNT_W'(REFRESH_DIV - 1)) begin
            r_refreshCnt <= '0;
            r_idx        <= (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_refreshCnt <= r_refreshCnt + 1'b1;
        end
    end

    // Output registers; polarity is applied only here
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_segs <= c_SEG_OFF;
            r_sel  <= c_SEL_OFF;
        end else begin
            r_segs <= (SEG_ACTIVE_LOW != 0) ? ~w_curSeg    : w_curSeg;
            r_sel  <= (SEG_ACTIVE_LOW != 0) ? ~w_selOneHot : w_selOneHot;
        end
    end

    assign segs = r_segs;
    assign sel  = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_n
// Description : Self-checking bench for seven_segment_n (4 digits, 16-bit
//               value, 4-cycle refresh, active-low outputs). Expected
//               displays come from an arithmetic model of the value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_n;

    localparam int ND = 4;
    localparam int VW = 16;
    localparam int RD = 4;
`ifdef SEVEN_SEGMENT_DECIMAL_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    // Lit segments {g,f,e,d,c,b,a} for glyphs 0..F
    localparam logic [6:0] TB_GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    typedef logic [6:0] seg_arr_t [16];
    typedef logic [3:0] sel_arr_t [16];

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic [VW-1:0] value = '0;
    logic          load = 1'b0;
    logic          decimalMode = 1'b0;
    logic          blankZeros = 1'b0;
    logic [6:0]    segs;
    logic [ND-1:0] sel;
    logic          busy;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    seven_segment_n #(
        .NUM_DIGITS     (ND),
        .VALUE_WIDTH    (VW),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .value       (value),
        .load        (load),
        .decimalMode (decimalMode),
        .blankZeros  (blankZeros),
        .segs        (segs),
        .sel         (sel),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Active-low segment pattern expected on digit i for a displayed number
    function automatic logic [6:0] model_seg(input longint unsigned v, input bit dec,
                                             input bit bz, input int i);
        longint unsigned base;
        longint unsigned lim;
        longint unsigned p;
        int              d;
        base = dec ? 64'd10 : 64'd16;
        lim  = 64'd1;
        p    = 64'd1;
        for (int j = 0; j < ND; j++) lim = lim * base;
        for (int j = 0; j < i; j++) p = p * base;
        if (v >= lim) return ~7'b1000000;
        if (bz && i > 0 && v < p) return ~7'b0000000;
        d = int'((v / p) % base);
        return ~TB_GLYPH[d];
    endfunction

    function automatic bit model_ovf(input longint unsigned v, input bit dec);
        return dec ? (v >= 64'd10000) : (v >= 64'd65536);
    endfunction

    function automatic int model_busy(input bit dec);
        return dec ? VW + 2 : 2;
    endfunction

    // Pulse load for one cycle and count the cycles busy stays high
    task automatic do_load(input logic [VW-1:0] v, input logic dec, output int busyCycles);
        @(negedge clk);
        value       = v;
        decimalMode = dec;
        load        = 1'b1;
        @(negedge clk);
        load       = 1'b0;
        busyCycles = 0;
        while (busy && busyCycles < 200) begin
            busyCycles++;
            @(negedge clk);
        end
    endtask

    // Record one full scan starting at a fresh digit-0 window
    task automatic capture_scan(output seg_arr_t so, output sel_arr_t lo, output bit found);
        logic [3:0] prev;
        found = 1'b0;
        @(negedge clk);
        prev = sel;
        for (int g = 0; g < 40 && !found; g++) begin
            @(negedge clk);
            if (sel == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = sel;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            so[k] = segs;
            lo[k] = sel;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (segs !== 7'h7F || sel !== 4'hF) begin
            fails++;
            $display("FAIL reset_outputs: segs=%b sel=%b, expected 1111111 1111", segs, sel);
        end
        tests++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: busy=%b overflow=%b, expected 0 0", busy, overflow);
        end
        rstN = 1'b1;
        @(negedge clk);
        tests++;
        if (sel !== 4'b1110 || segs !== ~TB_GLYPH[0]) begin
            fails++;
            $display("FAIL reset_first_digit: sel=%b segs=%b, expected 1110 %b", sel, segs, ~TB_GLYPH[0]);
        end
    endtask

    task automatic test_hex();
        int n; bit found; seg_arr_t so; sel_arr_t lo;
        logic [3:0] es; logic [6:0] ex;
        blankZeros = 1'b0;
        do_load(16'h1A2F, 1'b0, n);
        tests++;
        if (n != 2) begin
            fails++;
            $display("FAIL hex_busy: %0d cycles, expected 2", n);
        end
        capture_scan(so, lo, found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL hex_scan_start: digit0 window not found, expected within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            es = ~(4'b0001 << (k / 4));
            ex = model_seg(64'h1A2F, 1'b0, 1'b0, k / 4);
            tests++;
            if (lo[k] !== es || so[k] !== ex) begin
                fails++;
                $display("FAIL hex_scan cycle %0d: sel=%b segs=%b, expected sel=%b segs=%b", k, lo[k], so[k], es, ex);
            end
        end
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL hex_overflow: %b, expected 0", overflow);
        end
    endtask

    // Decimal loads (decimal build) or decimalMode ignored (hex-only build)
    task automatic test_decimal();
        int n; bit found; seg_arr_t so; sel_arr_t lo;
        logic [3:0] es; logic [6:0] ex;
        logic [VW-1:0] vals [2];
        blankZeros = 1'b0;
        vals[0] = DEC_EN ? 16'd1234 : 16'h0010;
        vals[1] = DEC_EN ? 16'd12345 : 16'h0010;
        for (int t = 0; t < 2; t++) begin
            do_load(vals[t], 1'b1, n);
            tests++;
            if (n != model_busy(DEC_EN)) begin
                fails++;
                $display("FAIL dec_busy[%0d]: %0d cycles, expected %0d", t, n, model_busy(DEC_EN));
            end
            capture_scan(so, lo, found);
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL dec_scan_start[%0d]: digit0 window not found, expected within 40 cycles", t);
            end
            for (int k = 0; k < 16; k++) begin
                es = ~(4'b0001 << (k / 4));
                ex = model_seg(longint'(vals[t]), DEC_EN, 1'b0, k / 4);
                tests++;
                if (lo[k] !== es || so[k] !== ex) begin
                    fails++;
                    $display("FAIL dec_scan[%0d] cycle %0d: sel=%b segs=%b, expected sel=%b segs=%b", t, k, lo[k], so[k], es, ex);
                end
            end
            tests++;
            if (overflow !== model_ovf(longint'(vals[t]), DEC_EN)) begin
                fails++;
                $display("FAIL dec_overflow[%0d]: %b, expected %b", t, overflow, model_ovf(longint'(vals[t]), DEC_EN));
            end
        end
    endtask

    task automatic test_blanking();
        int n; bit found; seg_arr_t so; sel_arr_t lo;
        logic [3:0] es; logic [6:0] ex;
        logic [VW-1:0] vals [2];
        vals[0] = 16'd7;
        vals[1] = 16'd0;
        blankZeros = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_load(vals[t], 1'b1, n);
            capture_scan(so, lo, found);
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL blank_scan_start[%0d]: digit0 window not found, expected within 40 cycles", t);
            end
            for (int k = 0; k < 16; k++) begin
                es = ~(4'b0001 << (k / 4));
                ex = model_seg(longint'(vals[t]), DEC_EN, 1'b1, k / 4);
                tests++;
                if (lo[k] !== es || so[k] !== ex) begin
                    fails++;
                    $display("FAIL blank_scan[%0d] cycle %0d: sel=%b segs=%b, expected sel=%b segs=%b", t, k, lo[k], so[k], es, ex);
                end
            end
        end
        blankZeros = 1'b0;
    endtask

    // Two loads while busy: only the newest survives, with no idle gap
    task automatic test_back_to_back();
        int n; bit found; seg_arr_t so; sel_arr_t lo;
        logic [3:0] es; logic [6:0] ex;
        blankZeros = 1'b0;
        @(negedge clk);
        value = 16'd5; decimalMode = 1'b1; load = 1'b1;
        @(negedge clk);
        n = busy ? 1 : 0;
        value = 16'h0005; decimalMode = 1'b0;
        @(negedge clk);
        n += busy ? 1 : 0;
        value = 16'h00BE;
        @(negedge clk);
        n += busy ? 1 : 0;
        load = 1'b0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        tests++;
        if (n != model_busy(DEC_EN) + 2) begin
            fails++;
            $display("FAIL b2b_busy: %0d cycles, expected %0d", n, model_busy(DEC_EN) + 2);
        end
        capture_scan(so, lo, found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL b2b_scan_start: digit0 window not found, expected within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            es = ~(4'b0001 << (k / 4));
            ex = model_seg(64'h00BE, 1'b0, 1'b0, k / 4);
            tests++;
            if (lo[k] !== es || so[k] !== ex) begin
                fails++;
                $display("FAIL b2b_scan cycle %0d: sel=%b segs=%b, expected sel=%b segs=%b", k, lo[k], so[k], es, ex);
            end
        end
    endtask

    task automatic test_random();
        int n; bit found; seg_arr_t so; sel_arr_t lo;
        logic [3:0] es; logic [6:0] ex;
        logic [VW-1:0] v; logic dec; bit eff; int r;
        for (int it = 0; it < 10; it++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      v = VW'($urandom_range(0, 20));
            else if (r == 1) v = VW'($urandom_range(0, 999));
            else             v = VW'($urandom_range(0, 65535));
            dec        = 1'($urandom_range(0, 1));
            blankZeros = 1'($urandom_range(0, 1));
            eff        = DEC_EN && dec;
            do_load(v, dec, n);
            tests++;
            if (n != model_busy(eff)) begin
                fails++;
                $display("FAIL rand_busy[%0d] v=%0d dec=%b: %0d cycles, expected %0d", it, v, dec, n, model_busy(eff));
            end
            capture_scan(so, lo, found);
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL rand_scan_start[%0d]: digit0 window not found, expected within 40 cycles", it);
            end
            for (int k = 0; k < 16; k++) begin
                es = ~(4'b0001 << (k / 4));
                ex = model_seg(longint'(v), eff, blankZeros, k / 4);
                tests++;
                if (lo[k] !== es || so[k] !== ex) begin
                    fails++;
                    $display("FAIL rand_scan[%0d] v=%0d dec=%b bz=%b cycle %0d: sel=%b segs=%b, expected sel=%b segs=%b",
                             it, v, dec, blankZeros, k, lo[k], so[k], es, ex);
                end
            end
            tests++;
            if (overflow !== model_ovf(longint'(v), eff)) begin
                fails++;
                $display("FAIL rand_overflow[%0d] v=%0d: %b, expected %b", it, v, overflow, model_ovf(longint'(v), eff));
            end
        end
        blankZeros = 1'b0;
    endtask

    // Reset mid-conversion with a request pending: everything is discarded
    task automatic test_reset_mid();
        bit found; seg_arr_t so; sel_arr_t lo;
        logic [3:0] es; logic [6:0] ex;
        blankZeros = 1'b0;
        @(negedge clk);
        value = 16'd1234; decimalMode = 1'b1; load = 1'b1;
        @(negedge clk);
        value = 16'h00AA;
        @(negedge clk);
        load = 1'b0;
        #1 rstN = 1'b0;
        #1;
        tests++;
        if (segs !== 7'h7F || sel !== 4'hF || busy !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: segs=%b sel=%b busy=%b ovf=%b, expected 1111111 1111 0 0",
                     segs, sel, busy, overflow);
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy: %b, expected 0", busy);
        end
        capture_scan(so, lo, found);
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL reset_mid_scan_start: digit0 window not found, expected within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            es = ~(4'b0001 << (k / 4));
            ex = model_seg(64'd0, 1'b0, 1'b0, k / 4);
            tests++;
            if (lo[k] !== es || so[k] !== ex) begin
                fails++;
                $display("FAIL reset_mid_scan cycle %0d: sel=%b segs=%b, expected sel=%b segs=%b", k, lo[k], so[k], es, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_blanking();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
